// File: rtl/conv_a1_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_a1_ctrl
//  Purpose  : Sequencer for the 25-tap floating-point convolution datapath.
//             For each filter it loads the K*K weights from weight memory,
//             then streams IFM pixels into the line-buffer FIFO. It enables
//             the multiplier stage only when the accepted pixel completes a
//             valid window, tags results through the pipeline latency, and
//             emits OFM write strobes and addresses for every filter.
//  Options  : CONV_A1_CTRL_STALL_CNT_EN - adds a 16-bit saturating counter
//             of STREAM cycles in which no pixel was offered (stall_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module conv_a1_ctrl #(
    parameter int IFM_SIZE              = 14,
    parameter int KERNAL_SIZE           = 5,
    parameter int NUMBER_OF_FILTERS     = 2,
    parameter int PIPE_LATENCY          = 6,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_WM       = $clog2(KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int FILTER_SEL_W          = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    output logic                             wm_rd_en,
    output logic [ADDRESS_SIZE_WM-1:0]       wm_addr,
    output logic                             w_load,
    output logic                             conv_enable,
    output logic [FILTER_SEL_W-1:0]          filter_sel,
    output logic                             ofm_we,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_addr,
    output logic                             busy,
    output logic                             done
`ifdef CONV_A1_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_cnt
`endif
);

    localparam int KK = KERNAL_SIZE * KERNAL_SIZE;
    localparam int LW = (KK > 1) ? $clog2(KK) : 1;
    localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int AW = ADDRESS_SIZE_WM;
    localparam int OW = ADDRESS_SIZE_NEXT_IFM;
    localparam int FW = FILTER_SEL_W;

    localparam logic [LW-1:0] LD_LAST  = LW'(KK - 1);
    localparam logic [CW-1:0] PIX_LAST = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0] WIN_MIN  = CW'(KERNAL_SIZE - 1);
    localparam logic [OW-1:0] OFM_LAST = OW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [FW-1:0] FS_LAST  = FW'(NUMBER_OF_FILTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           ld_cnt_q, ld_cnt_d;
    logic [AW-1:0]           wm_addr_q, wm_addr_d;
    logic [CW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [FW-1:0]           filter_q, filter_d;
    logic [OW-1:0]           ofm_addr_q, ofm_addr_d;
    logic [PIPE_LATENCY-1:0] vsr_q;
    logic                    w_load_q;

    // Next-state and combinational outputs; every output defaults low so
    // IDLE (and therefore reset) drives all-zero.
    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        wm_addr_d   = wm_addr_q;
        row_d       = row_q;
        col_d       = col_q;
        filter_d    = filter_q;
        ofm_addr_d  = ofm_addr_q;
        pix_ready   = 1'b0;
        wm_rd_en    = 1'b0;
        wm_addr     = '0;
        conv_enable = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);

        // Output address follows each write strobe and wraps at the last pixel
        if (vsr_q[PIPE_LATENCY-1]) begin
            ofm_addr_d = (ofm_addr_q == OFM_LAST) ? '0 : ofm_addr_q + OW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD_W;
                    filter_d   = '0;
                    ld_cnt_d   = '0;
                    wm_addr_d  = '0;
                    row_d      = '0;
                    col_d      = '0;
                    ofm_addr_d = '0;
                end
            end

            // Weight addresses run contiguously across filters, so the
            // running address equals filter*K*K + i without a multiplier.
            S_LOAD_W: begin
                wm_rd_en  = 1'b1;
                wm_addr   = wm_addr_q;
                wm_addr_d = wm_addr_q + AW'(1);
                if (ld_cnt_q == LD_LAST) begin
                    ld_cnt_d = '0;
                    state_d  = S_STREAM;
                end else begin
                    ld_cnt_d = ld_cnt_q + LW'(1);
                end
            end

            S_STREAM: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    // Window complete only when both coordinates reach K-1;
                    // windows straddling a row wrap fail the column test.
                    conv_enable = (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
                    if (col_q == PIX_LAST) begin
                        col_d = '0;
                        if (row_q == PIX_LAST) begin
                            row_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (vsr_q == '0) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (filter_q == FS_LAST) begin
                    state_d = S_DONE;
                end else begin
                    filter_d   = filter_q + FW'(1);
                    row_d      = '0;
                    col_d      = '0;
                    ofm_addr_d = '0;
                    state_d    = S_LOAD_W;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            wm_addr_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            filter_q   <= '0;
            ofm_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            wm_addr_q  <= wm_addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            filter_q   <= filter_d;
            ofm_addr_q <= ofm_addr_d;
        end
    end

    // Weight load strobe trails the read by the one-cycle memory latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_load_q <= 1'b0;
        end else begin
            w_load_q <= wm_rd_en;
        end
    end

    // Valid tag pipeline shifts every cycle because the adder stages free-run
    generate
        if (PIPE_LATENCY > 1) begin : g_vsr_shift
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vsr_q <= '0;
                end else begin
                    vsr_q <= {vsr_q[PIPE_LATENCY-2:0], conv_enable};
                end
            end
        end else begin : g_vsr_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vsr_q <= '0;
                end else begin
                    vsr_q <= conv_enable;
                end
            end
        end
    endgenerate

`ifdef CONV_A1_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of STREAM cycles without an offered pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
        end else if ((state_q == S_STREAM) && !pix_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign w_load     = w_load_q;
    assign ofm_we     = vsr_q[PIPE_LATENCY-1];
    assign ofm_addr   = ofm_addr_q;
    assign filter_sel = filter_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_a1_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_conv_a1_ctrl
//  Purpose  : Scoreboard bench for conv_a1_ctrl. A reference model derives
//             expected weight addresses and OFM writes from pixel indices;
//             a monitor pops and compares as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_a1_ctrl;

    localparam int IFM = 14;
    localparam int K   = 5;
    localparam int NF  = 2;
    localparam int PL  = 6;
    localparam int ON  = IFM - K + 1;
    localparam int AW  = $clog2(K * K * NF);
    localparam int OW  = $clog2(ON * ON);
    localparam int FW  = (NF > 1) ? $clog2(NF) : 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          wm_rd_en;
    logic [AW-1:0] wm_addr;
    logic          w_load;
    logic          conv_enable;
    logic [FW-1:0] filter_sel;
    logic          ofm_we;
    logic [OW-1:0] ofm_addr;
    logic          busy;
    logic          done;
`ifdef CONV_A1_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    conv_a1_ctrl #(
        .IFM_SIZE          (IFM),
        .KERNAL_SIZE       (K),
        .NUMBER_OF_FILTERS (NF),
        .PIPE_LATENCY      (PL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .wm_rd_en    (wm_rd_en),
        .wm_addr     (wm_addr),
        .w_load      (w_load),
        .conv_enable (conv_enable),
        .filter_sel  (filter_sel),
        .ofm_we      (ofm_we),
        .ofm_addr    (ofm_addr),
        .busy        (busy),
        .done        (done)
`ifdef CONV_A1_CTRL_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int filt;
        int addr;
        int cyc;
    } ofm_t;

    ofm_t ofm_q[$];
    int   wm_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_pct = 100;
    int mdl_pix = 0, mdl_filt = 0, mdl_addr = 0;
    int ofm_cnt = 0, done_cnt = 0, stall_mdl = 0;
    int rd_start = 0, rd_len = 0, wl_len = 0, done_cyc = -10;
    bit prev_rd = 1'b0, prev_wl = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint all_out();
        longint v;
        v = longint'({pix_ready, wm_rd_en, wm_addr, w_load, conv_enable,
                      filter_sel, ofm_we, ofm_addr, busy, done});
`ifdef CONV_A1_CTRL_STALL_CNT_EN
        v = v | longint'(stall_cnt);
`endif
        return v;
    endfunction

    // Pixel source: random offer each cycle at the configured percentage
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_valid = ($urandom_range(0, 99) < valid_pct);
        end
    end

    // Monitor: advances the reference model on handshakes and checks outputs
    always @(negedge clk) begin
        int  row, col;
        bit  win;
        ofm_t e;

        if (wm_rd_en) begin
            if (!prev_rd) begin
                rd_start = cyc;
                rd_len   = 0;
            end
            rd_len++;
            chk("wm_expected", wm_q.size() > 0, 1);
            if (wm_q.size() > 0) chk("wm_addr", wm_addr, wm_q.pop_front());
        end else if (prev_rd) begin
            chk("wm_rd_len", rd_len, K * K);
        end

        if (w_load) begin
            if (!prev_wl) begin
                chk("w_load_lag", cyc - rd_start, 1);
                wl_len = 0;
            end
            wl_len++;
        end else if (prev_wl) begin
            chk("w_load_len", wl_len, K * K);
        end
        prev_rd = wm_rd_en;
        prev_wl = w_load;

        if (pix_ready) begin
            if (!pix_valid) begin
                stall_mdl++;
                chk("conv_en_stall", conv_enable, 0);
            end else begin
                row = mdl_pix / IFM;
                col = mdl_pix % IFM;
                win = (row >= K - 1) && (col >= K - 1);
                chk("conv_en_window", conv_enable, win);
                if (win) begin
                    ofm_q.push_back('{mdl_filt, mdl_addr, cyc + PL});
                    mdl_addr++;
                end
                mdl_pix++;
                if (mdl_pix == IFM * IFM) begin
                    mdl_pix  = 0;
                    mdl_addr = 0;
                    mdl_filt++;
                end
            end
        end else begin
            chk("conv_en_not_ready", conv_enable, 0);
        end

        if (ofm_we) begin
            ofm_cnt++;
            chk("ofm_expected", ofm_q.size() > 0, 1);
            if (ofm_q.size() > 0) begin
                e = ofm_q.pop_front();
                chk("ofm_addr", ofm_addr, e.addr);
                chk("ofm_filter", filter_sel, e.filt);
                chk("ofm_cycle", cyc, e.cyc);
            end
        end

        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 1);
        end
        if (cyc == done_cyc + 1) chk("busy_after_done", busy, 0);
    end

    task automatic begin_layer(input int pct);
        valid_pct = pct;
        mdl_pix   = 0;
        mdl_filt  = 0;
        mdl_addr  = 0;
        ofm_cnt   = 0;
        done_cnt  = 0;
        stall_mdl = 0;
        ofm_q.delete();
        wm_q.delete();
        for (int f = 0; f < NF; f++)
            for (int i = 0; i < K * K; i++)
                wm_q.push_back(f * K * K + i);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_layer(input int pct, input bit inject_start);
        bit got;
        got = 1'b0;
        begin_layer(pct);
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (inject_start && c == 150) start = 1'b1;
            if (inject_start && c == 151) start = 1'b0;
            if (done_cnt > 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("layer_done_in_budget", got, 1);
        repeat (3) @(negedge clk);
        chk("ofm_total", ofm_cnt, NF * ON * ON);
        chk("done_count", done_cnt, 1);
        chk("ofm_leftover", ofm_q.size(), 0);
        chk("wm_leftover", wm_q.size(), 0);
        chk("idle_after_layer", busy, 0);
`ifdef CONV_A1_CTRL_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_mdl);
`endif
    endtask

    initial begin
        bit reached;

        // Reset, then idle with start low
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", all_out(), 0);
        end

        // Full layer with continuous pixels, then with random stalls and a
        // start pulse issued while busy that must be ignored
        run_layer(100, 1'b0);
        run_layer(50, 1'b1);

        // Abort mid-stream in filter 0
        begin_layer(100);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (mdl_pix >= 60 && mdl_filt == 0) begin
                reached = 1'b1;
                break;
            end
        end
        chk("abort_point_reached", reached, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("abort_outputs", all_out(), 0);
        ofm_q.delete();
        wm_q.delete();
        done_cnt = 0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_still_zero", all_out(), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Layer after the abort must be complete and correct
        run_layer(100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/conv_a1_ctrl.md
Name: conv_a1_ctrl

Overview:
- Sequencer for the 25-tap floating-point convolution datapath (5x5 multiplier array, adder tree, 6-cycle pipeline).
- Per filter, it loads the K*K weights from weight memory, then streams IFM pixels into the line-buffer FIFO.
- It drives conv_enable only when the FIFO holds a complete window, and tags results through the pipeline latency.
- It outputs output-feature-map write strobes and addresses, and loops over all filters.

Parameters:
- IFM_SIZE, 14, input feature map edge length.
- KERNAL_SIZE, 5, kernel edge length.
- NUMBER_OF_FILTERS, 2, number of filter passes.
- PIPE_LATENCY, 6, cycles from conv_enable to valid conv_data_out.
- IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, output edge length.
- ADDRESS_SIZE_WM, $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS), weight address width.
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), output address width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset (asserted at 0).
- start, in, 1: single-cycle request to begin a layer.
- pix_valid, in, 1: IFM pixel available.
- pix_ready, out, 1: controller accepts a pixel; the FIFO shifts when pix_valid & pix_ready.
- wm_rd_en, out, 1: weight memory read strobe.
- wm_addr, out, ADDRESS_SIZE_WM: weight memory address.
- w_load, out, 1: weight shift-register load; wm_rd_en delayed 1 cycle to match the 1-cycle memory read latency.
- conv_enable, out, 1: datapath multiplier-stage enable.
- filter_sel, out, $clog2(NUMBER_OF_FILTERS) (minimum 1): current filter index.
- ofm_we, out, 1: conv_data_out is valid this cycle.
- ofm_addr, out, ADDRESS_SIZE_NEXT_IFM: output pixel address.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the layer completes.

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters 0; every output 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, NEXT, DONE.
- IDLE:
  - start=1 -> LOAD_W; filter_sel=0.
  - start is ignored in every other state.
- LOAD_W:
  - wm_rd_en=1 for exactly K*K consecutive cycles.
  - wm_addr = filter_sel*K*K + i, with i = 0..K*K-1.
  - After the last read -> STREAM. w_load trails wm_rd_en by 1 cycle.
- STREAM:
  - pix_ready=1. Row/col counters advance only on pix_valid&pix_ready; col wraps at IFM_SIZE-1 and increments row.
  - conv_enable = accept & row>=K-1 & col>=K-1, so the pixel just accepted completes a valid window. Windows straddling the row wrap are suppressed.
  - pix_valid=0 stalls: counters hold and conv_enable=0.
  - Accepting pixel (IFM_SIZE-1, IFM_SIZE-1) -> DRAIN.
- Valid tagging:
  - PIPE_LATENCY-deep shift register, input conv_enable, shifting every cycle (not gated). The datapath adder stages free-run.
  - ofm_we = shift register tap PIPE_LATENCY-1, i.e. PIPE_LATENCY cycles after conv_enable.
- Output addressing:
  - ofm_addr increments after each ofm_we.
  - It resets to 0 at the start of each filter pass and never exceeds IFM_SIZE_NEXT^2-1.
- DRAIN:
  - pix_ready=0. Wait until the valid shift register is all-zero -> NEXT.
- NEXT:
  - If filter_sel==NUMBER_OF_FILTERS-1 -> DONE.
  - Otherwise filter_sel+1 and reset row/col/ofm_addr -> LOAD_W.
- DONE: done=1 for one cycle -> IDLE.
- busy=0 only in IDLE.
- Exactly IFM_SIZE_NEXT^2 ofm_we pulses per filter.
- Reset mid-operation aborts immediately; no further ofm_we or done is issued.

Optional Feature:
- Macro: CONV_A1_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits): counts STREAM cycles with pix_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared on IDLE->LOAD_W and on reset.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=0 then 1 with start=0 for 20 cycles -> all outputs 0, busy=0.
- Weight load: pulse start -> wm_rd_en high for 25 cycles with wm_addr 0..24; w_load high for cycles 1..25. Second pass reads wm_addr 25..49.
- Full layer, continuous pix_valid=1 (14x14, K=5, 2 filters):
  - 100 ofm_we per filter; ofm_addr 0..99 each pass; 200 ofm_we total.
  - First ofm_we occurs 6 cycles after the conv_enable of pixel (4,4).
  - done pulses once; busy falls the cycle after done.
- Stalls: pix_valid random 50% -> same 200 ofm_we in the same address order; conv_enable never high while pix_valid=0. With the macro enabled, stall_cnt equals the number of stalled STREAM cycles.
- Row boundary: in row 4, pixels at cols 0..3 -> conv_enable=0; col 4 -> conv_enable=1.
- Reset mid-stream: assert reset during filter 0 at pixel 60 -> outputs 0 immediately. A subsequent start runs a full, correct layer (200 ofm_we). A start issued while busy is ignored.
